decode_stage_pipe: RTL and testbench
====================================

# decode_stage_pipe

Parametrised, registered instruction-decode stage for the RV32/RV64 pipeline, placed between the fetch unit and the DU register / issue logic. Decodes opcode, funct fields, register addresses and enables, sign-extended immediate and shift amount, and flags illegal encodings. Results go into a 2-entry skid buffer with valid/ready handshake, so `ready_o` is registered and never combinationally depends on `ready_i`. A synchronous flush discards buffered instructions.

## Interface
- `XLEN`, 64, datapath width; legal values 32 or 64.
- `PID_W`, 2, width of the pipeline/way ID tag carried with each instruction.
- `SHW`, $clog2(XLEN), width of `shamt_o`. Derived; do not override.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  synchronous kill of all buffered and incoming instructions.
- `valid_i`  in  1  fetch offers an instruction.
- `inst_i`  in  32  instruction word.
- `inst_addr_i`  in  32  instruction PC.
- `pid_i`  in  PID_W  ID tag.
- `rs1_data_i`, `rs2_data_i`  in  XLEN  regfile read data for this cycle's `rs1_addr_o`/`rs2_addr_o`.
- `ready_o`  out  1  stage can accept.
- `rs1_addr_o`, `rs2_addr_o`  out  5  combinational regfile read addresses decoded from `inst_i`.
- `rs1_re_o`, `rs2_re_o`  out  1  combinational regfile read enables decoded from `inst_i`.
- `valid_o`  out  1  head entry valid.
- `ready_i`  in  1  downstream accepts the head entry.
- `inst_addr_o`, `pid_o`, `rs1_data_o`, `rs2_data_o`, `rd_addr_o`, `rd_we_o`, `imm_o` (XLEN), `opcode_o` (7), `funct3_o` (3), `funct7_o` (7), `shamt_o` (SHW), `illegal_o` (1)  out  head entry fields.

## Operation
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011, SYSTEM 1110011, OPIMM32 0011011, OP32 0111011, AMO 0101111, OPFP 1010011.
- When XLEN=32, OPIMM32 and OP32 are illegal. Any other opcode is also illegal. An illegal instruction has all enables 0, all addresses 0, imm 0, and `illegal_o`=1.
- `rs1_re`/`rs1_addr`=inst[19:15] for JALR, BRANCH, LOAD, STORE, OPIMM, OP, OPIMM32, OP32, AMO, OPFP. Also for SYSTEM when funct3 is not 000 or 100.
- `rs2_re`/`rs2_addr`=inst[24:20] for BRANCH, STORE, OP, OP32, AMO, OPFP. A disabled address reads 0.
- `rd_addr`=inst[11:7] for all legal opcodes except BRANCH and STORE, which give 0. JALR uses inst[11:7] and is not forced to x1.
- `rd_we`=1 for LUI, AUIPC, JAL, JALR, OPIMM, OPIMM32, AMO, OPFP.
- `rd_we` for OP/OP32 = (funct7 != 0000001); M-extension writeback happens in the MDU.
- `rd_we` for SYSTEM = (funct3 not in {000,100}).
- `rd_we`=0 for LOAD (written in MEM), BRANCH and STORE.
- Immediates, sign-extended to XLEN:
  - I: JALR, LOAD, OPIMM, OPIMM32, SYSTEM.
  - S: STORE.
  - B: {inst31, inst7, inst30:25, inst11:8, 0}.
  - U: inst[31:12] sign-extended, not shifted (execute shifts).
  - J: {inst31, inst19:12, inst20, inst30:21, 0}.
  - OP, OP32, AMO, OPFP: imm 0.
- `shamt`:
  - OPIMM with funct3=001 and inst[31:26]=000000, or funct3=101 and inst[31:26] in {000000, 010000}: shamt = inst[25:20] (XLEN=64) or inst[24:20] (XLEN=32). At XLEN=32, inst[25]=1 is illegal.
  - OPIMM32 with funct3 in {001,101}: shamt = zero-extended inst[24:20].
  - Otherwise shamt is 0.
- Buffer: occupancy `cnt` in {0,1,2}; states EMPTY, ONE, FULL. Entries are written in arrival order, head first.
  - Accept = `valid_i && ready_o && !flush_i`.
  - Pop = `valid_o && ready_i`.
  - `cnt_next = cnt + accept - pop`. With accept and pop in the same cycle, occupancy is unchanged and the head advances.
- `ready_o` = (cnt != 2) && !rst. It depends only on registered state.
- `valid_o` = (cnt != 0).
- Flush: next cycle `cnt`=0. The instruction offered in the flush cycle is dropped, and a pop in that cycle is ignored (not re-presented).

## Timing
- Decode is combinational from `inst_i`. Regfile addresses and enables are combinational outputs in the same cycle.
- Captured fields appear on outputs 1 cycle after accept when the buffer was empty or popping. Throughput is 1 instruction/cycle.
- `rst` high: next edge sets `cnt`=0. After reset, `valid_o`=0, all data outputs 0 and `ready_o`=1. `ready_o` is 0 while `rst` is high.
- `rst` has priority over `flush_i`, and `flush_i` has priority over accept/pop.
- Head outputs are stable while `valid_o && !ready_i`.

## Test plan
- **Reset:** hold rst 2 cycles mid-stream with cnt=2 -> valid_o=0, ready_o=1, imm_o=0 the cycle after release.
- **Back-to-back decode, ready_i=1:**
  - `addi x5,x1,-1` (0xFFF08293) -> rd=5, rd_we=1, rs1_re=1, imm=all-ones.
  - `jalr x3,0(x2)` (0x000101E7) -> rd_addr=3.
  - Each appears 1 cycle after accept.
- **Backpressure:** ready_i=0 while 3 instructions are offered -> first two buffered, ready_o=0 after second. Release -> outputs in order, no loss, no duplication.
- **Flush with cnt=2 plus a concurrent offer** -> next cycle valid_o=0, cnt=0. The offered instruction is never output.
- **XLEN=32 build:**
  - `addiw` (opcode 0011011) -> illegal_o=1, rd_we=0.
  - `slli x1,x1,33` -> illegal.
  - `slli x1,x1,31` -> shamt=31.
- **M/CSR/U-type:**
  - `mul` (funct7=0000001, OP) -> rd_we=0.
  - `csrrw` (funct3=001) -> rs1_re=1, rd_we=1.
  - `lui x1,0x80000` -> imm=0xFFFFFFFFFFF80000 at XLEN=64.

Source files
------------

// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_pipe
// Purpose  : RV32/RV64 instruction decode feeding a 2-entry skid buffer
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage_pipe #(
  parameter int XLEN  = 64,
  parameter int PID_W = 2,
  parameter int SHW   = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic [PID_W-1:0] pid_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  output logic             ready_o,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  output logic             rs1_re_o,
  output logic             rs2_re_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      inst_addr_o,
  output logic [PID_W-1:0] pid_o,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [4:0]       rd_addr_o,
  output logic             rd_we_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [6:0]       opcode_o,
  output logic [2:0]       funct3_o,
  output logic [6:0]       funct7_o,
  output logic [SHW-1:0]   shamt_o,
  output logic             illegal_o
);

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OP_OP32    = 7'b0111011;
  localparam logic [6:0] OP_AMO     = 7'b0101111;
  localparam logic [6:0] OP_OPFP    = 7'b1010011;
  localparam logic       IS_RV64    = (XLEN == 64);

  typedef struct packed {
    logic [31:0]      inst_addr;
    logic [PID_W-1:0] pid;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [4:0]       rd_addr;
    logic             rd_we;
    logic [XLEN-1:0]  imm;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [SHW-1:0]   shamt;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [SHW-1:0]  shamt_imm;
  logic            shamt_bad;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  assign imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {{(XLEN-20){inst_i[31]}}, inst_i[31:12]};
  assign imm_j = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // RV32 has only 5 shift-amount bits; a set bit 25 is not a valid encoding there.
  if (XLEN == 64) begin : g_shamt_rv64
    assign shamt_imm = inst_i[25:20];
    assign shamt_bad = 1'b0;
  end else begin : g_shamt_rv32
    assign shamt_imm = inst_i[24:20];
    assign shamt_bad = inst_i[25];
  end

  logic            legal, rs1_en, rs2_en, rd_en, dec_we, sys_rw, shift_imm;
  logic [XLEN-1:0] dec_imm;
  logic [SHW-1:0]  dec_shamt;

  always_comb begin
    legal     = 1'b1;
    rs1_en    = 1'b0;
    rs2_en    = 1'b0;
    rd_en     = 1'b0;
    dec_we    = 1'b0;
    dec_imm   = '0;
    dec_shamt = '0;
    sys_rw    = (funct3 != 3'b000) && (funct3 != 3'b100);
    shift_imm = ((funct3 == 3'b001) && (funct7[6:1] == 6'b000000)) ||
                ((funct3 == 3'b101) && ((funct7[6:1] == 6'b000000) ||
                                        (funct7[6:1] == 6'b010000)));
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        rd_en = 1'b1; dec_we = 1'b1; dec_imm = imm_u;
      end
      OP_JAL: begin
        rd_en = 1'b1; dec_we = 1'b1; dec_imm = imm_j;
      end
      OP_JALR: begin
        rs1_en = 1'b1; rd_en = 1'b1; dec_we = 1'b1; dec_imm = imm_i;
      end
      OP_BRANCH: begin
        rs1_en = 1'b1; rs2_en = 1'b1; dec_imm = imm_b;
      end
      OP_LOAD: begin
        rs1_en = 1'b1; rd_en = 1'b1; dec_imm = imm_i;
      end
      OP_STORE: begin
        rs1_en = 1'b1; rs2_en = 1'b1; dec_imm = imm_s;
      end
      OP_OPIMM: begin
        rs1_en = 1'b1; rd_en = 1'b1; dec_we = 1'b1; dec_imm = imm_i;
        if (shift_imm) begin
          if (shamt_bad) legal = 1'b0;
          else           dec_shamt = shamt_imm;
        end
      end
      OP_OP: begin
        rs1_en = 1'b1; rs2_en = 1'b1; rd_en = 1'b1;
        dec_we = (funct7 != 7'b0000001);
      end
      OP_SYSTEM: begin
        rs1_en = sys_rw; rd_en = 1'b1; dec_we = sys_rw; dec_imm = imm_i;
      end
      OP_OPIMM32: begin
        if (!IS_RV64) legal = 1'b0;
        else begin
          rs1_en = 1'b1; rd_en = 1'b1; dec_we = 1'b1; dec_imm = imm_i;
          if ((funct3 == 3'b001) || (funct3 == 3'b101)) dec_shamt = SHW'(inst_i[24:20]);
        end
      end
      OP_OP32: begin
        if (!IS_RV64) legal = 1'b0;
        else begin
          rs1_en = 1'b1; rs2_en = 1'b1; rd_en = 1'b1;
          dec_we = (funct7 != 7'b0000001);
        end
      end
      OP_AMO, OP_OPFP: begin
        rs1_en = 1'b1; rs2_en = 1'b1; rd_en = 1'b1; dec_we = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      rs1_en    = 1'b0;
      rs2_en    = 1'b0;
      rd_en     = 1'b0;
      dec_we    = 1'b0;
      dec_imm   = '0;
      dec_shamt = '0;
    end
  end

  assign rs1_re_o   = rs1_en;
  assign rs2_re_o   = rs2_en;
  assign rs1_addr_o = rs1_en ? inst_i[19:15] : 5'd0;
  assign rs2_addr_o = rs2_en ? inst_i[24:20] : 5'd0;

  entry_t in_entry;

  always_comb begin
    in_entry           = '0;
    in_entry.inst_addr = inst_addr_i;
    in_entry.pid       = pid_i;
    in_entry.rs1_data  = rs1_data_i;
    in_entry.rs2_data  = rs2_data_i;
    in_entry.rd_addr   = rd_en ? inst_i[11:7] : 5'd0;
    in_entry.rd_we     = dec_we;
    in_entry.imm       = dec_imm;
    in_entry.opcode    = opcode;
    in_entry.funct3    = funct3;
    in_entry.funct7    = funct7;
    in_entry.shamt     = dec_shamt;
    in_entry.illegal   = !legal;
  end

  state_t state, state_next;
  entry_t head_q, tail_q;
  logic   accept, pop, load_head, load_tail, shift_tail;

  // ready_o looks only at registered occupancy and rst, never at ready_i.
  assign ready_o = (state != FULL) && !rst;
  assign valid_o = (state != EMPTY);
  assign accept  = valid_i && ready_o && !flush_i;
  assign pop     = valid_o && ready_i;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_head  = 1'b0;
    load_tail  = 1'b0;
    shift_tail = 1'b0;
    if (flush_i) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            load_head  = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_head = 1'b1;
          end else if (accept) begin
            state_next = FULL;
            load_tail  = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_next = ONE;
            shift_tail = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head)       head_q <= in_entry;
      else if (shift_tail) head_q <= tail_q;
      if (load_tail)       tail_q <= in_entry;
    end
  end

  assign inst_addr_o = head_q.inst_addr;
  assign pid_o       = head_q.pid;
  assign rs1_data_o  = head_q.rs1_data;
  assign rs2_data_o  = head_q.rs2_data;
  assign rd_addr_o   = head_q.rd_addr;
  assign rd_we_o     = head_q.rd_we;
  assign imm_o       = head_q.imm;
  assign opcode_o    = head_q.opcode;
  assign funct3_o    = head_q.funct3;
  assign funct7_o    = head_q.funct7;
  assign shamt_o     = head_q.shamt;
  assign illegal_o   = head_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// Bench for decode_stage_pipe: RV64 and RV32 builds driven in lockstep against
// an architectural decode model and a queue model of the skid buffer.
module tb_decode_stage_pipe;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011, OPIMM32 = 7'b0011011, OP32 = 7'b0111011;
  localparam logic [6:0] AMO = 7'b0101111, OPFP = 7'b1010011;

  logic        clk = 1'b0, rst = 1'b1, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [31:0] inst_i = '0, inst_addr_i = '0;
  logic [1:0]  pid_i = '0;
  logic [63:0] rs1_d = '0, rs2_d = '0;

  logic        a_ready, a_rs1_re, a_rs2_re, a_valid, a_rd_we, a_ill;
  logic [4:0]  a_rs1_addr, a_rs2_addr, a_rd;
  logic [31:0] a_addr;
  logic [1:0]  a_pid;
  logic [63:0] a_rs1, a_rs2, a_imm;
  logic [6:0]  a_op, a_f7;
  logic [2:0]  a_f3;
  logic [5:0]  a_sh;

  logic        b_ready, b_rs1_re, b_rs2_re, b_valid, b_rd_we, b_ill;
  logic [4:0]  b_rs1_addr, b_rs2_addr, b_rd;
  logic [31:0] b_addr;
  logic [1:0]  b_pid;
  logic [31:0] b_rs1, b_rs2, b_imm;
  logic [6:0]  b_op, b_f7;
  logic [2:0]  b_f3;
  logic [4:0]  b_sh;

  always #5 clk = ~clk;

  decode_stage_pipe #(.XLEN(64), .PID_W(2)) dut64 (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .inst_i(inst_i),
    .inst_addr_i(inst_addr_i), .pid_i(pid_i), .rs1_data_i(rs1_d), .rs2_data_i(rs2_d),
    .ready_o(a_ready), .rs1_addr_o(a_rs1_addr), .rs2_addr_o(a_rs2_addr),
    .rs1_re_o(a_rs1_re), .rs2_re_o(a_rs2_re), .valid_o(a_valid), .ready_i(ready_i),
    .inst_addr_o(a_addr), .pid_o(a_pid), .rs1_data_o(a_rs1), .rs2_data_o(a_rs2),
    .rd_addr_o(a_rd), .rd_we_o(a_rd_we), .imm_o(a_imm), .opcode_o(a_op),
    .funct3_o(a_f3), .funct7_o(a_f7), .shamt_o(a_sh), .illegal_o(a_ill)
  );

  decode_stage_pipe #(.XLEN(32), .PID_W(2)) dut32 (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .inst_i(inst_i),
    .inst_addr_i(inst_addr_i), .pid_i(pid_i), .rs1_data_i(rs1_d[31:0]),
    .rs2_data_i(rs2_d[31:0]),
    .ready_o(b_ready), .rs1_addr_o(b_rs1_addr), .rs2_addr_o(b_rs2_addr),
    .rs1_re_o(b_rs1_re), .rs2_re_o(b_rs2_re), .valid_o(b_valid), .ready_i(ready_i),
    .inst_addr_o(b_addr), .pid_o(b_pid), .rs1_data_o(b_rs1), .rs2_data_o(b_rs2),
    .rd_addr_o(b_rd), .rd_we_o(b_rd_we), .imm_o(b_imm), .opcode_o(b_op),
    .funct3_o(b_f3), .funct7_o(b_f7), .shamt_o(b_sh), .illegal_o(b_ill)
  );

  typedef struct {
    bit          legal;
    bit          r1;
    bit          r2;
    bit          rdv;
    bit          we;
    logic [63:0] imm;
    logic [5:0]  sh;
  } dec_t;

  typedef struct {
    logic [31:0] w;
    logic [31:0] addr;
    logic [1:0]  pid;
    logic [63:0] d1;
    logic [63:0] d2;
    dec_t        e64;
    dec_t        e32;
  } ent_t;

  ent_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural decode, derived from the ISA field rules with plain arithmetic.
  function automatic dec_t ref_dec(input logic [31:0] w, input int xl);
    dec_t       d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [5:0] hi6;
    longint     s;
    bit         sysrw;
    op    = w[6:0];
    f3    = w[14:12];
    hi6   = w[31:26];
    s     = longint'($signed(w));
    sysrw = !(f3 inside {3'd0, 3'd4});
    d.legal = (op inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, SYSTEM,
                          OPIMM32, OP32, AMO, OPFP}) &&
              !(xl == 32 && (op inside {OPIMM32, OP32}));
    d.r1  = (op inside {JALR, BRANCH, LOAD, STORE, OPIMM, OP, OPIMM32, OP32, AMO, OPFP}) ||
            (op == SYSTEM && sysrw);
    d.r2  = op inside {BRANCH, STORE, OP, OP32, AMO, OPFP};
    d.rdv = !(op inside {BRANCH, STORE});
    d.we  = (op inside {LUI, AUIPC, JAL, JALR, OPIMM, OPIMM32, AMO, OPFP}) ||
            ((op inside {OP, OP32}) && w[31:25] != 7'b0000001) ||
            (op == SYSTEM && sysrw);
    d.imm = '0;
    d.sh  = '0;
    if (op inside {JALR, LOAD, OPIMM, OPIMM32, SYSTEM}) d.imm = s >>> 20;
    else if (op == STORE)  d.imm = ((s >>> 25) <<< 5) | longint'(w[11:7]);
    else if (op == BRANCH) d.imm = ((s >>> 31) <<< 12) | (longint'(w[7]) << 11) |
                                   (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
    else if (op inside {LUI, AUIPC}) d.imm = s >>> 12;
    else if (op == JAL)    d.imm = ((s >>> 31) <<< 20) | (longint'(w[19:12]) << 12) |
                                   (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
    if (op == OPIMM && ((f3 == 3'd1 && hi6 == 6'd0) ||
                        (f3 == 3'd5 && (hi6 inside {6'd0, 6'b010000})))) begin
      if (xl == 32 && w[25]) d.legal = 1'b0;
      else d.sh = (xl == 64) ? w[25:20] : {1'b0, w[24:20]};
    end
    if (op == OPIMM32 && (f3 inside {3'd1, 3'd5})) d.sh = {1'b0, w[24:20]};
    if (!d.legal) begin
      d.r1 = 1'b0; d.r2 = 1'b0; d.rdv = 1'b0; d.we = 1'b0; d.imm = '0; d.sh = '0;
    end
    return d;
  endfunction

  task automatic check_outputs();
    ent_t e;
    chk("valid64", a_valid, q.size() != 0);
    chk("valid32", b_valid, q.size() != 0);
    chk("ready64", a_ready, (q.size() != 2) && !rst);
    chk("ready32", b_ready, (q.size() != 2) && !rst);
    if (q.size() != 0) begin
      e = q[0];
      chk("addr64", a_addr, e.addr);
      chk("pid64",  a_pid,  e.pid);
      chk("rs1d64", a_rs1,  e.d1);
      chk("rs2d64", a_rs2,  e.d2);
      chk("rd64",   a_rd,   e.e64.rdv ? e.w[11:7] : 5'd0);
      chk("we64",   a_rd_we, e.e64.we);
      chk("imm64",  a_imm,  e.e64.imm);
      chk("op64",   a_op,   e.w[6:0]);
      chk("f3_64",  a_f3,   e.w[14:12]);
      chk("f7_64",  a_f7,   e.w[31:25]);
      chk("sh64",   a_sh,   e.e64.sh);
      chk("ill64",  a_ill,  !e.e64.legal);
      chk("addr32", b_addr, e.addr);
      chk("pid32",  b_pid,  e.pid);
      chk("rs1d32", b_rs1,  e.d1[31:0]);
      chk("rs2d32", b_rs2,  e.d2[31:0]);
      chk("rd32",   b_rd,   e.e32.rdv ? e.w[11:7] : 5'd0);
      chk("we32",   b_rd_we, e.e32.we);
      chk("imm32",  b_imm,  e.e32.imm[31:0]);
      chk("op32",   b_op,   e.w[6:0]);
      chk("sh32",   b_sh,   e.e32.sh);
      chk("ill32",  b_ill,  !e.e32.legal);
    end
  endtask

  // One clock: drive at negedge, check decode outputs, update model, check after edge.
  task automatic step(input bit v, input logic [31:0] w, input bit rdy, input bit fl);
    ent_t e;
    bit   acc;
    bit   pp;
    valid_i     = v;
    inst_i      = w;
    ready_i     = rdy;
    flush_i     = fl;
    inst_addr_i = $urandom;
    pid_i       = 2'($urandom);
    rs1_d       = {$urandom, $urandom};
    rs2_d       = {$urandom, $urandom};
    #1;
    e.w    = w;
    e.addr = inst_addr_i;
    e.pid  = pid_i;
    e.d1   = rs1_d;
    e.d2   = rs2_d;
    e.e64  = ref_dec(w, 64);
    e.e32  = ref_dec(w, 32);
    chk("rs1re64", a_rs1_re, e.e64.r1);
    chk("rs2re64", a_rs2_re, e.e64.r2);
    chk("rs1a64",  a_rs1_addr, e.e64.r1 ? w[19:15] : 5'd0);
    chk("rs2a64",  a_rs2_addr, e.e64.r2 ? w[24:20] : 5'd0);
    chk("rs1re32", b_rs1_re, e.e32.r1);
    chk("rs2re32", b_rs2_re, e.e32.r2);
    chk("rs1a32",  b_rs1_addr, e.e32.r1 ? w[19:15] : 5'd0);
    chk("rs2a32",  b_rs2_addr, e.e32.r2 ? w[24:20] : 5'd0);
    acc = v && (q.size() < 2) && !fl && !rst;
    pp  = (q.size() != 0) && rdy;
    if (rst || fl) q.delete();
    else begin
      if (pp)  void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  ops [16];
    logic [31:0] r;
    logic [31:0] w;
    ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, SYSTEM,
            OPIMM32, OP32, AMO, OPFP, 7'h00, 7'h7F};

    @(negedge clk);
    step(0, 32'h0, 0, 0);
    rst = 1'b0;
    step(0, 32'h0, 1, 0);
    chk("rst_imm64",  a_imm,  64'h0);
    chk("rst_addr64", a_addr, 64'h0);
    chk("rst_rd32",   b_rd,   64'h0);

    // back-to-back decode
    step(1, 32'hFFF08293, 1, 0);
    chk("addi_rd",  a_rd,    64'd5);
    chk("addi_we",  a_rd_we, 64'd1);
    chk("addi_imm", a_imm,   64'hFFFF_FFFF_FFFF_FFFF);
    step(1, 32'h000101E7, 1, 0);
    chk("jalr_rd", a_rd, 64'd3);
    step(0, 32'h0, 1, 0);

    // backpressure: third offer must be refused
    step(1, 32'h12345037, 0, 0);
    step(1, 32'h00A00513, 0, 0);
    chk("bp_ready", a_ready, 64'd0);
    step(1, 32'h00B50633, 0, 0);
    repeat (3) step(0, 32'h0, 1, 0);

    // flush while full with a concurrent offer
    step(1, 32'h00A00513, 0, 0);
    step(1, 32'h00B50633, 0, 0);
    step(1, 32'h12345037, 1, 1);
    chk("flush_valid", a_valid, 64'd0);
    repeat (2) step(0, 32'h0, 1, 0);

    // reset mid-stream with the buffer full
    step(1, 32'h00A00513, 0, 0);
    step(1, 32'h00B50633, 0, 0);
    rst = 1'b1;
    step(1, 32'h12345037, 1, 0);
    step(0, 32'h0, 1, 0);
    rst = 1'b0;
    step(0, 32'h0, 1, 0);
    chk("rst2_valid", a_valid, 64'd0);
    chk("rst2_ready", a_ready, 64'd1);
    chk("rst2_imm",   a_imm,   64'h0);

    // RV32 legality and shift amounts, M/CSR/U-type
    step(1, 32'h0000009B, 1, 0);
    chk("addiw_ill32", b_ill,   64'd1);
    chk("addiw_we32",  b_rd_we, 64'd0);
    chk("addiw_ill64", a_ill,   64'd0);
    step(1, 32'h02109093, 1, 0);
    chk("slli33_ill32", b_ill, 64'd1);
    chk("slli33_sh64",  a_sh,  64'd33);
    step(1, 32'h01F09093, 1, 0);
    chk("slli31_sh32", b_sh, 64'd31);
    step(1, 32'h023100B3, 1, 0);
    chk("mul_we", a_rd_we, 64'd0);
    step(1, 32'h300110F3, 1, 0);
    chk("csrrw_we", a_rd_we, 64'd1);
    step(1, 32'h800000B7, 1, 0);
    chk("lui_imm", a_imm, 64'hFFFF_FFFF_FFF8_0000);
    step(0, 32'h0, 1, 0);

    // randomized traffic with backpressure and occasional flush
    repeat (400) begin
      r = $urandom;
      if ($urandom_range(0, 1) == 1) r[31:26] = ($urandom_range(0, 1) == 1) ? 6'b000000 : 6'b010000;
      w = {r[31:7], ops[$urandom_range(0, 15)]};
      step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    repeat (3) step(0, 32'h0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
